// File: rtl/regfile_dumper_pkg.sv
// Shared definitions for the register-file dump engine: FSM encoding and
// stream framing constants.
package regfile_dumper_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_HDR  = 3'd2,
      S_READ = 3'd3,
      S_SEND = 3'd4,
      S_DONE = 3'd5
   } state_t;

   localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
   localparam logic [4:0] LAST_REG         = 5'd31;
   localparam logic [1:0] LAST_BYTE        = 2'd3;

endpackage : regfile_dumper_pkg

// File: rtl/regfile_dumper.sv
// Freezes the pipeline, then streams all 32 registers (optionally after a
// sync byte) as little-endian bytes over a valid/ready byte interface.
module regfile_dumper
   import regfile_dumper_pkg::*;
#(
   parameter bit         HEADER_EN = 1'b1,
   parameter logic [7:0] HDR_BYTE  = HDR_BYTE_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        stall_req,
   input  logic        stall_ack,
   output logic [4:0]  rf_addr,
   input  logic [31:0] rf_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        done
);

   state_t      state_reg, state_next;
   logic [4:0]  reg_cnt_reg, reg_cnt_next;
   logic [1:0]  byte_cnt_reg, byte_cnt_next;
   logic [31:0] shift_reg, shift_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= S_IDLE;
         reg_cnt_reg  <= '0;
         byte_cnt_reg <= '0;
         shift_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         reg_cnt_reg  <= reg_cnt_next;
         byte_cnt_reg <= byte_cnt_next;
         shift_reg    <= shift_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      reg_cnt_next  = reg_cnt_reg;
      byte_cnt_next = byte_cnt_reg;
      shift_next    = shift_reg;
      stall_req     = 1'b0;
      rf_addr       = '0;
      tx_data       = '0;
      tx_valid      = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next   = S_REQ;
               reg_cnt_next = '0;
            end
         end

         S_REQ: begin
            busy      = 1'b1;
            stall_req = 1'b1;
            if (stall_ack) begin
               state_next = HEADER_EN ? S_HDR : S_READ;
            end
         end

         // Losing the grant after it was given abandons the dump at once:
         // nothing is offered downstream and the FSM goes home.
         S_HDR: begin
            busy = 1'b1;
            if (!stall_ack) begin
               state_next = S_IDLE;
            end else begin
               stall_req = 1'b1;
               tx_valid  = 1'b1;
               tx_data   = HDR_BYTE;
               if (tx_ready) begin
                  state_next = S_READ;
               end
            end
         end

         S_READ: begin
            busy = 1'b1;
            if (!stall_ack) begin
               state_next = S_IDLE;
            end else begin
               stall_req     = 1'b1;
               rf_addr       = reg_cnt_reg;
               shift_next    = rf_data;
               byte_cnt_next = '0;
               state_next    = S_SEND;
            end
         end

         S_SEND: begin
            busy = 1'b1;
            if (!stall_ack) begin
               state_next = S_IDLE;
            end else begin
               stall_req = 1'b1;
               tx_valid  = 1'b1;
               tx_data   = shift_reg[7:0];
               if (tx_ready) begin
                  shift_next    = {8'h00, shift_reg[31:8]};
                  byte_cnt_next = byte_cnt_reg + 2'd1;
                  if (byte_cnt_reg == LAST_BYTE) begin
                     // Terminal compare on 31 so the counter never wraps.
                     if (reg_cnt_reg == LAST_REG) begin
                        state_next = S_DONE;
                     end else begin
                        reg_cnt_next = reg_cnt_reg + 5'd1;
                        state_next   = S_READ;
                     end
                  end
               end
            end
         end

         S_DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = S_IDLE;
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

endmodule : regfile_dumper

// File: tb/tb_regfile_dumper.sv
// Self-checking bench: table of dump scenarios against a byte-stream model,
// plus hand sequences for grant loss and reset mid-dump.
`timescale 1ns/1ps
module tb_regfile_dumper;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, start, sel_n, stall_ack, tx_ready;
   logic start_h, start_n;
   assign start_h = start & ~sel_n;
   assign start_n = start & sel_n;

   logic        stall_req_h, tx_valid_h, busy_h, done_h;
   logic [4:0]  rf_addr_h;
   logic [7:0]  tx_data_h;
   logic [31:0] rf_data_h;
   logic        stall_req_n, tx_valid_n, busy_n, done_n;
   logic [4:0]  rf_addr_n;
   logic [7:0]  tx_data_n;
   logic [31:0] rf_data_n;

   // Register file model: r0 is hardwired to zero.
   logic [31:0] rf [32];
   assign rf_data_h = (rf_addr_h == 5'd0) ? 32'h0 : rf[rf_addr_h];
   assign rf_data_n = (rf_addr_n == 5'd0) ? 32'h0 : rf[rf_addr_n];

   regfile_dumper #(.HEADER_EN(1'b1), .HDR_BYTE(8'hA5)) dut_h (
      .clk(clk), .reset(reset), .start(start_h), .stall_req(stall_req_h),
      .stall_ack(stall_ack), .rf_addr(rf_addr_h), .rf_data(rf_data_h),
      .tx_data(tx_data_h), .tx_valid(tx_valid_h), .tx_ready(tx_ready),
      .busy(busy_h), .done(done_h)
   );

   regfile_dumper #(.HEADER_EN(1'b0), .HDR_BYTE(8'hA5)) dut_n (
      .clk(clk), .reset(reset), .start(start_n), .stall_req(stall_req_n),
      .stall_ack(stall_ack), .rf_addr(rf_addr_n), .rf_data(rf_data_n),
      .tx_data(tx_data_n), .tx_valid(tx_valid_n), .tx_ready(tx_ready),
      .busy(busy_n), .done(done_n)
   );

   logic       cur_stall_req, cur_tx_valid, cur_busy, cur_done;
   logic [4:0] cur_rf_addr;
   logic [7:0] cur_tx_data;
   always_comb begin
      cur_stall_req = sel_n ? stall_req_n : stall_req_h;
      cur_tx_valid  = sel_n ? tx_valid_n  : tx_valid_h;
      cur_busy      = sel_n ? busy_n      : busy_h;
      cur_done      = sel_n ? done_n      : done_h;
      cur_rf_addr   = sel_n ? rf_addr_n   : rf_addr_h;
      cur_tx_data   = sel_n ? tx_data_n   : tx_data_h;
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input longint actual, input longint expected);
      tests++;
      if (actual != expected) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Reference stream: optional sync byte, then every register LSB first.
   logic [7:0] exp_q[$];
   task automatic build_expected(input bit hdr);
      logic [31:0] v;
      exp_q.delete();
      if (hdr) exp_q.push_back(8'hA5);
      for (int r = 0; r < 32; r++) begin
         v = (r == 0) ? 32'h0 : rf[r];
         for (int b = 0; b < 4; b++) exp_q.push_back(v[8*b +: 8]);
      end
   endtask

   task automatic fill_rf(input bit rnd);
      for (int i = 0; i < 32; i++) rf[i] = rnd ? $urandom() : (32'h1000_0000 + i);
   endtask

   task automatic run_dump(input string tag, input bit hdr, input int ready_mode,
                           input int ack_delay, input bit extra, input int exp_len);
      logic [7:0] got_q[$];
      logic [7:0] prev_data;
      bit prev_stall, finished;
      int done_cnt, wait_bad, stab_bad, addr_bad, mism, restart_bad, done_stall;
      prev_data = '0; prev_stall = 0; finished = 0;
      done_cnt = 0; wait_bad = 0; stab_bad = 0; addr_bad = 0; mism = 0;
      restart_bad = 0; done_stall = 0;
      build_expected(hdr);
      sel_n = !hdr;
      for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
         @(posedge clk); #1;
         start     = (cyc == 0) || extra;
         stall_ack = (cyc >= ack_delay);
         case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (cyc % 2 == 0);
            default: tx_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (cyc >= 1 && cyc <= ack_delay && !(cur_stall_req && !cur_tx_valid && cur_busy)) wait_bad++;
         if (prev_stall && (!cur_tx_valid || cur_tx_data != prev_data)) stab_bad++;
         if (cur_tx_valid && cur_rf_addr != 5'd0) addr_bad++;
         if (cur_tx_valid && tx_ready) got_q.push_back(cur_tx_data);
         prev_stall = cur_tx_valid && !tx_ready;
         prev_data  = cur_tx_data;
         if (cur_done) begin
            done_cnt++;
            finished = 1;
            if (cur_stall_req) done_stall++;
         end
      end
      // start is still high during the DONE cycle in the extra-start runs
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         start = 1'b0; stall_ack = 1'b0; tx_ready = 1'b0;
         #1;
         if (cur_done) done_cnt++;
         if (cur_busy) restart_bad++;
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] != exp_q[i]) begin
            if (mism == 0) $display("FAIL %s_byte[%0d]: got %0h, expected %0h", tag, i, got_q[i], exp_q[i]);
            mism++;
         end
      check({tag, "_finished"}, finished, 1);
      check({tag, "_len"}, got_q.size(), exp_len);
      check({tag, "_byte_mismatches"}, mism, 0);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_stall_req_in_done"}, done_stall, 0);
      check({tag, "_wait_phase_bad"}, wait_bad, 0);
      check({tag, "_unstable_tx"}, stab_bad, 0);
      check({tag, "_rf_addr_outside_read"}, addr_bad, 0);
      check({tag, "_restart_after_done"}, restart_bad, 0);
      $display("[TB] run %s: %0d bytes, %0d done pulse(s)", tag, got_q.size(), done_cnt);
   endtask

   typedef struct {
      string tag;
      bit    hdr;
      int    ready_mode;
      int    ack_delay;
      bit    extra;
      bit    rand_rf;
      int    exp_len;
   } vec_t;

   initial begin
      vec_t vecs[6];
      int nb, wait_bad, mism, done_seen;
      bit hit;

      vecs[0] = '{"hdr_ready1",    1'b1, 0, 3, 1'b0, 1'b0, 129};
      vecs[1] = '{"hdr_toggle",    1'b1, 1, 3, 1'b0, 1'b0, 129};
      vecs[2] = '{"nohdr_extra",   1'b0, 0, 2, 1'b1, 1'b0, 128};
      vecs[3] = '{"hdr_rand",      1'b1, 2, 5, 1'b0, 1'b1, 129};
      vecs[4] = '{"nohdr_rand_ex", 1'b0, 2, 1, 1'b1, 1'b1, 128};
      vecs[5] = '{"hdr_rand_ack0", 1'b1, 2, 0, 1'b1, 1'b1, 129};

      reset = 1'b0; start = 1'b0; sel_n = 1'b0; stall_ack = 1'b0; tx_ready = 1'b0;
      fill_rf(1'b0);
      #12;
      check("reset_outputs_hdr", {stall_req_h, tx_valid_h, tx_data_h, busy_h, done_h, rf_addr_h}, 0);
      check("reset_outputs_nohdr", {stall_req_n, tx_valid_n, tx_data_n, busy_n, done_n, rf_addr_n}, 0);
      @(negedge clk); reset = 1'b1;
      repeat (2) @(posedge clk);

      for (int v = 0; v < 6; v++) begin
         fill_rf(vecs[v].rand_rf);
         run_dump(vecs[v].tag, vecs[v].hdr, vecs[v].ready_mode, vecs[v].ack_delay,
                  vecs[v].extra, vecs[v].exp_len);
      end

      // Long grant wait, then the grant is withdrawn after 10 bytes.
      fill_rf(1'b0); sel_n = 1'b0; build_expected(1'b1);
      nb = 0; wait_bad = 0; mism = 0; hit = 0;
      for (int cyc = 0; cyc < 300 && !hit; cyc++) begin
         @(posedge clk); #1;
         start = (cyc == 0); tx_ready = 1'b1;
         stall_ack = (cyc >= 20) && (nb < 10);
         #1;
         if (cyc >= 1 && cyc <= 20 && !(cur_stall_req && !cur_tx_valid && cur_busy)) wait_bad++;
         if (nb >= 10) begin
            hit = 1;
            check("abort_cycle_outputs", {cur_stall_req, cur_tx_valid}, 0);
         end else if (cur_tx_valid && tx_ready) begin
            if (cur_tx_data != exp_q[nb]) mism++;
            nb++;
         end
      end
      check("abort_reached", hit, 1);
      check("ack_wait_phase_bad", wait_bad, 0);
      check("abort_prefix_mismatches", mism, 0);
      @(posedge clk); #2;
      check("abort_idle_next_cycle", {cur_busy, cur_stall_req, cur_tx_valid}, 0);
      done_seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #2;
         if (cur_done || cur_busy) done_seen++;
      end
      check("abort_no_done", done_seen, 0);
      $display("[TB] run abort: %0d bytes before grant loss", nb);

      // Reset in the middle of register 7, then a fresh dump.
      fill_rf(1'b1); build_expected(1'b1);
      nb = 0; hit = 0;
      for (int cyc = 0; cyc < 300 && !hit; cyc++) begin
         @(posedge clk); #1;
         start = (cyc == 0); tx_ready = 1'b1; stall_ack = (cyc >= 3);
         #1;
         if (cur_tx_valid && tx_ready) nb++;
         if (nb == 31) begin
            #2 reset = 1'b0;
            #1;
            hit = 1;
            check("reset_mid_dump_outputs", {stall_req_h, tx_valid_h, tx_data_h, busy_h, done_h, rf_addr_h}, 0);
         end
      end
      check("reset_mid_dump_reached", hit, 1);
      $display("[TB] run reset_mid: reset after %0d bytes", nb);
      start = 1'b0; stall_ack = 1'b0; tx_ready = 1'b0;
      @(negedge clk); reset = 1'b1;
      repeat (2) @(posedge clk);
      run_dump("post_reset", 1'b1, 0, 3, 1'b0, 129);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_regfile_dumper

// File: doc/regfile_dumper.md
REGFILE_DUMPER -- requirements
Module: regfile_dumper

Interface
REQ-001 Parameter: HEADER_EN, 1, when 1 a sync byte 8'hA5 precedes each dump; when 0 no header is sent.
REQ-002 Parameter: HDR_BYTE, 8'hA5, value of the header byte.
REQ-003 Port: clk  input  1  clock, all state changes on posedge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  dump request, sampled only in IDLE.
REQ-006 Port: stall_req  output  1  asks the pipeline to freeze so the register file is stable.
REQ-007 Port: stall_ack  input  1  pipeline is frozen; no register-file write occurs while high.
REQ-008 Port: rf_addr  output  5  register-file read-port address.
REQ-009 Port: rf_data  input  32  combinational read data for rf_addr.
REQ-010 Port: tx_data  output  8  byte stream data.
REQ-011 Port: tx_valid  output  1  tx_data is valid.
REQ-012 Port: tx_ready  input  1  sink accepts the byte when tx_valid && tx_ready at posedge.
REQ-013 Port: busy  output  1  high from leaving IDLE until return to IDLE.
REQ-014 Port: done  output  1  one-cycle pulse when the last byte is accepted.

Function
REQ-015 FSM states SHALL be IDLE, REQ, HDR, READ, SEND, DONE.
REQ-016 IDLE: on start=1, go to REQ and clear reg counter to 0.
REQ-017 REQ: stall_req=1; wait for stall_ack=1, then go to HDR if HEADER_EN else READ.
REQ-018 HDR: tx_valid=1, tx_data=HDR_BYTE; on handshake go to READ.
REQ-019 READ: rf_addr=reg counter; capture rf_data into a 32-bit shift register at the posedge; go to SEND with byte counter 0; one cycle only.
REQ-020 SEND: tx_valid=1, tx_data=shift[7:0]; each handshake shifts right by 8 and increments the byte counter; 4 bytes per register, little-endian.
REQ-021 After the 4th byte: if reg counter=31 go to DONE, else increment reg counter and go to READ.
REQ-022 Register 0 SHALL be dumped like the others (expected value 0); 32 registers x 4 bytes = 128 data bytes per dump.
REQ-023 DONE: done=1 for one cycle, stall_req drops, go to IDLE.
REQ-024 stall_req SHALL stay high from REQ through the end of SEND of register 31.
REQ-025 tx_valid, once high, SHALL stay high with tx_data stable until accepted; tx_ready low stalls indefinitely.
REQ-026 stall_ack falling after grant SHALL abort: outputs idle, no done, return to IDLE next cycle.
REQ-027 start while busy SHALL be ignored; start and DONE in the same cycle do not restart.
REQ-028 The 5-bit reg counter SHALL never wrap; the terminal test is counter==31.
REQ-029 rf_addr SHALL be 0 outside READ.

Reset
REQ-030 reset low SHALL force IDLE immediately: stall_req=0, tx_valid=0, tx_data=0, busy=0, done=0, rf_addr=0, counters and shift register 0.
REQ-031 Reset mid-dump SHALL discard the dump; a new dump always starts with the header/register 0.

Structure
REQ-032 State encoding and HDR_BYTE default belong in the shared processor package.
REQ-033 No sub-module; a single FSM with counters and a shift register.

Verification
REQ-034 RF preloaded with reg[i]=32'h1000_0000+i, start pulse, stall_ack after 3 cycles, tx_ready=1 -> bytes A5, 00,00,00,00 (r0 hardwired), 01,00,00,10, ..., 1F,00,00,10; done after 129 bytes.
REQ-035 Same, with tx_ready toggled 1/0 every cycle -> identical byte sequence, tx_data stable while tx_valid && !tx_ready.
REQ-036 stall_ack held low 20 cycles -> stall_req=1, tx_valid=0 throughout, busy=1.
REQ-037 stall_ack dropped after 10 bytes -> return to IDLE, no done, stall_req=0.
REQ-038 reset asserted during SEND of register 7 -> all outputs 0 asynchronously; next start yields a full dump from A5.
REQ-039 HEADER_EN=0, start during busy -> 128 bytes without header, extra start ignored, single done pulse.
